// File: rtl/rv_core_mc.sv
// Multi-cycle RV32I/RV64I integer core: FETCH -> EXEC (-> SHIFT x n) with one retire per instruction.
// Latency 2 cycles per instruction (2+n for shifts by n); fetch stalls indefinitely until IMEM_ACK.
module rv_core_mc #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              NREGS    = 32
) (
  input  logic            CLOCK,
  input  logic            RESET,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_ACK,
  input  logic [31:0]     IMEM_DATA,
  output logic [XLEN-1:0] PC,
  output logic            RETIRE,
  output logic            TRAP,
  input  logic [4:0]      DBG_RADDR,
  output logic [XLEN-1:0] DBG_RDATA
);
  localparam int SW       = (XLEN == 64) ? 6 : 5;
  localparam int RIW      = (NREGS == 16) ? 4 : 5;
  localparam bit SMALL_RF = (NREGS == 16);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_SHIFT, S_HALT} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [31:0]     ir;
  logic [XLEN-1:0] gpr [NREGS];
  logic [XLEN-1:0] sreg;
  logic [SW-1:0]   cnt;
  shkind_t         kind;

  logic [6:0]      opc, f7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] i_imm, u_imm, b_imm, j_imm;
  logic [XLEN-1:0] rs1_v, rs2_v, op2, pc4, tgt, wr_val, sh_next;
  logic            illegal, wr_en, shift_go, take, use_rs1, use_rs2;
  logic [SW-1:0]   shamt;
  shkind_t         sh_kind;

  function automatic logic bad_idx(input logic [4:0] idx);
    return SMALL_RF && idx[4];
  endfunction

  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  assign i_imm = XLEN'($signed(ir[31:20]));
  assign u_imm = XLEN'($signed({ir[31:12], 12'b0}));
  assign b_imm = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
  assign j_imm = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));

  assign rs1_v = (rs1 == 5'd0 || bad_idx(rs1)) ? '0 : gpr[rs1[RIW-1:0]];
  assign rs2_v = (rs2 == 5'd0 || bad_idx(rs2)) ? '0 : gpr[rs2[RIW-1:0]];
  assign pc4   = pc + XLEN'(4);
  assign op2   = (opc == OPC_OP) ? rs2_v : i_imm;

  always_comb begin
    illegal  = 1'b0;
    wr_en    = 1'b0;
    wr_val   = '0;
    tgt      = pc4;
    shift_go = 1'b0;
    shamt    = '0;
    sh_kind  = SH_LL;
    take     = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (opc)
      OPC_LUI: begin
        wr_en  = 1'b1;
        wr_val = u_imm;
      end
      OPC_AUIPC: begin
        wr_en  = 1'b1;
        wr_val = pc + u_imm;
      end
      OPC_JAL: begin
        wr_en  = 1'b1;
        wr_val = pc4;
        tgt    = pc + j_imm;
      end
      OPC_JALR: begin
        use_rs1 = 1'b1;
        wr_en   = 1'b1;
        wr_val  = pc4;
        tgt     = (rs1_v + i_imm) & ~XLEN'(1);
        illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        case (f3)
          3'b000:  take = (rs1_v == rs2_v);
          3'b001:  take = (rs1_v != rs2_v);
          3'b100:  take = ($signed(rs1_v) <  $signed(rs2_v));
          3'b101:  take = ($signed(rs1_v) >= $signed(rs2_v));
          3'b110:  take = (rs1_v <  rs2_v);
          3'b111:  take = (rs1_v >= rs2_v);
          default: illegal = 1'b1;
        endcase
        if (take) tgt = pc + b_imm;
      end
      OPC_OPIMM, OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = (opc == OPC_OP);
        wr_en   = 1'b1;
        if (opc == OPC_OP)
          illegal = (f7 != 7'h00 && f7 != 7'h20) ||
                    (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101);
        case (f3)
          3'b000: wr_val = (opc == OPC_OP && f7[5]) ? rs1_v - op2 : rs1_v + op2;
          3'b010: wr_val = {{(XLEN-1){1'b0}}, $signed(rs1_v) < $signed(op2)};
          3'b011: wr_val = {{(XLEN-1){1'b0}}, rs1_v < op2};
          3'b100: wr_val = rs1_v ^ op2;
          3'b110: wr_val = rs1_v | op2;
          3'b111: wr_val = rs1_v & op2;
          default: begin
            shamt   = op2[SW-1:0];
            sh_kind = (f3 == 3'b001) ? SH_LL : (f7[5] ? SH_RA : SH_RL);
            // imm[5] is a shamt bit only on RV64; imm[10] only selects SRAI
            if (opc == OPC_OPIMM)
              illegal = ir[31] || (ir[29:26] != 4'd0) || ((XLEN == 32) && ir[25]) ||
                        (f3 == 3'b001 && ir[30]);
            if (shamt == '0) wr_val = rs1_v;
            else             shift_go = 1'b1;
          end
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (tgt[1]) illegal = 1'b1;
    if ((wr_en && bad_idx(rd)) || (use_rs1 && bad_idx(rs1)) || (use_rs2 && bad_idx(rs2)))
      illegal = 1'b1;
  end

  always_comb begin
    case (kind)
      SH_LL:   sh_next = sreg << 1;
      SH_RL:   sh_next = sreg >> 1;
      default: sh_next = {sreg[XLEN-1], sreg[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      sreg  <= '0;
      cnt   <= '0;
      kind  <= SH_LL;
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (IMEM_ACK) begin
            ir    <= IMEM_DATA;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (illegal) begin
            state <= S_HALT;
          end else if (shift_go) begin
            sreg  <= rs1_v;
            cnt   <= shamt;
            kind  <= sh_kind;
            state <= S_SHIFT;
          end else begin
            if (wr_en && rd != 5'd0) gpr[rd[RIW-1:0]] <= wr_val;
            pc    <= tgt;
            state <= S_FETCH;
          end
        end
        S_SHIFT: begin
          sreg <= sh_next;
          cnt  <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            if (rd != 5'd0) gpr[rd[RIW-1:0]] <= sh_next;
            pc    <= pc4;
            state <= S_FETCH;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    DBG_RDATA = '0;
    if (DBG_RADDR != 5'd0 && !bad_idx(DBG_RADDR)) DBG_RDATA = gpr[DBG_RADDR[RIW-1:0]];
  end

  assign IMEM_REQ  = (state == S_FETCH) && !RESET;
  assign IMEM_ADDR = pc;
  assign PC        = pc;
  assign TRAP      = (state == S_HALT);
  assign RETIRE    = (state == S_EXEC && !illegal && !shift_go) ||
                     (state == S_SHIFT && cnt == SW'(1));

endmodule

// File: tb/tb_rv_core_mc.sv
// Directed bench for rv_core_mc: one XLEN=32 and one XLEN=64 instance sharing a program memory.
module tb_rv_core_mc;
  localparam logic [6:0] OPIMM = 7'h13;
  localparam logic [6:0] OP    = 7'h33;

  logic        clk = 1'b0;
  logic        rst32 = 1'b1, rst64 = 1'b1, ack = 1'b1, sel64 = 1'b0;
  logic [4:0]  dbg = 5'd0;
  logic [31:0] mem [0:255];
  int          total = 0, bad = 0;

  logic        req32, ret32, trap32, req64, ret64, trap64;
  logic [31:0] addr32, pc32, rdata32, data32, data64;
  logic [63:0] addr64, pc64, rdata64;
  logic        m_req, m_ret, m_trap;
  logic [63:0] m_addr, m_pc, m_rdata;

  always #5 clk = ~clk;

  assign data32  = mem[addr32[9:2]];
  assign data64  = mem[addr64[9:2]];
  assign m_req   = sel64 ? req64  : req32;
  assign m_ret   = sel64 ? ret64  : ret32;
  assign m_trap  = sel64 ? trap64 : trap32;
  assign m_addr  = sel64 ? addr64  : {32'b0, addr32};
  assign m_pc    = sel64 ? pc64    : {32'b0, pc32};
  assign m_rdata = sel64 ? rdata64 : {32'b0, rdata32};

  rv_core_mc #(.XLEN(32), .RESET_PC(32'h0), .NREGS(32)) u_dut32 (
    .CLOCK(clk), .RESET(rst32), .IMEM_REQ(req32), .IMEM_ADDR(addr32), .IMEM_ACK(ack),
    .IMEM_DATA(data32), .PC(pc32), .RETIRE(ret32), .TRAP(trap32),
    .DBG_RADDR(dbg), .DBG_RDATA(rdata32));

  rv_core_mc #(.XLEN(64), .RESET_PC(64'h0), .NREGS(32)) u_dut64 (
    .CLOCK(clk), .RESET(rst64), .IMEM_REQ(req64), .IMEM_ADDR(addr64), .IMEM_ACK(ack),
    .IMEM_DATA(data64), .PC(pc64), .RETIRE(ret64), .TRAP(trap64),
    .DBG_RADDR(dbg), .DBG_RDATA(rdata64));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd,
                                        input logic [6:0] opc);
    logic [11:0] im; logic [4:0] a, d; logic [2:0] f;
    im = imm[11:0]; a = rs1[4:0]; d = rd[4:0]; f = f3[2:0];
    return {im, a, f, d, opc};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3,
                                        input int rd);
    logic [6:0] g; logic [4:0] a, b, d; logic [2:0] f;
    g = f7[6:0]; b = rs2[4:0]; a = rs1[4:0]; f = f3[2:0]; d = rd[4:0];
    return {g, b, a, f, d, OP};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd);
    logic [19:0] u; logic [4:0] d;
    u = imm20[19:0]; d = rd[4:0];
    return {u, d, 7'h37};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [12:0] b; logic [4:0] x, y; logic [2:0] f;
    b = imm[12:0]; x = rs2[4:0]; y = rs1[4:0]; f = f3[2:0];
    return {b[12], b[10:5], x, y, f, b[4:1], b[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] j; logic [4:0] d;
    j = imm[20:0]; d = rd[4:0];
    return {j[20], j[10:1], j[11], j[19:12], d, 7'h6F};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic chkreg(input string tag, input int idx, input logic [63:0] exp);
    dbg = idx[4:0];
    #1;
    check(tag, m_rdata, exp);
  endtask

  // Holds both cores in reset, checks reset outputs, then releases the selected one just after a rising edge.
  task automatic do_reset(input logic use64);
    logic [63:0] acc;
    @(negedge clk);
    sel64 = use64; rst32 = 1'b1; rst64 = 1'b1;
    @(negedge clk);
    check("rst_req",  64'(m_req),  64'd0);
    check("rst_pc",   m_pc,        64'd0);
    check("rst_addr", m_addr,      64'd0);
    check("rst_ret",  64'(m_ret),  64'd0);
    check("rst_trap", 64'(m_trap), 64'd0);
    acc = 64'd0;
    for (int i = 0; i < 32; i++) begin
      dbg = i[4:0];
      #0.1;
      acc = acc | m_rdata;
    end
    check("rst_dbg", acc, 64'd0);
    @(posedge clk);
    #1;
    rst32 = use64; rst64 = ~use64;
  endtask

  task automatic run_ret(input string tag, input int n, input int budget, output int cyc);
    int got;
    got = 0; cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (m_ret) got++;
    end
    check(tag, 64'(got), 64'(n));
  endtask

  initial begin
    int cyc, rcount;

    // add/sub with wraparound, zero-wait fetch
    clear_mem();
    mem[0] = enc_i(5, 0, 0, 1, OPIMM);
    mem[1] = enc_i(-3, 0, 0, 2, OPIMM);
    mem[2] = enc_r(0, 2, 1, 0, 3);
    mem[3] = enc_r(32, 1, 2, 0, 4);
    ack = 1'b1;
    do_reset(1'b0);
    run_ret("t1_ret", 4, 20, cyc);
    check("t1_cycles", 64'(cyc), 64'd8);
    @(negedge clk);
    chkreg("t1_x1", 1, 64'd5);
    chkreg("t1_x3", 3, 64'd2);
    chkreg("t1_x4", 4, 64'hFFFF_FFF8);

    // signed vs unsigned compares, long arithmetic shift
    clear_mem();
    mem[0] = enc_i(-1, 0, 0, 1, OPIMM);
    mem[1] = enc_i(0, 1, 2, 5, OPIMM);
    mem[2] = enc_i(0, 1, 3, 6, OPIMM);
    mem[3] = enc_r(0, 1, 0, 2, 7);
    mem[4] = enc_u(20'h80000, 8);
    mem[5] = enc_i(12'h41F, 8, 5, 9, OPIMM);
    do_reset(1'b0);
    run_ret("t2_ret5", 5, 30, cyc);
    check("t2_cycles5", 64'(cyc), 64'd10);
    run_ret("t2_srai_ret", 1, 60, cyc);
    check("t2_srai_cycles", 64'(cyc), 64'd33);
    @(negedge clk);
    chkreg("t2_x5", 5, 64'd1);
    chkreg("t2_x6", 6, 64'd0);
    chkreg("t2_x7", 7, 64'd0);
    chkreg("t2_x8", 8, 64'h8000_0000);
    chkreg("t2_x9", 9, 64'hFFFF_FFFF);

    // fetch backpressure, then reset in the 10th shift cycle
    clear_mem();
    mem[0] = enc_i(3, 0, 0, 1, OPIMM);
    mem[1] = enc_i(20, 1, 1, 2, OPIMM);
    ack = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_wait_req",  64'(m_req), 64'd1);
      check("t3_wait_addr", m_addr,     64'd0);
      check("t3_wait_ret",  64'(m_ret), 64'd0);
    end
    ack = 1'b1;
    run_ret("t3_first_ret", 1, 10, cyc);
    check("t3_first_lat", 64'(cyc), 64'd1);
    repeat (12) @(negedge clk);
    check("t3_mid_ret", 64'(m_ret), 64'd0);
    rst32 = 1'b1;
    #1;
    check("t3_rst_req", 64'(m_req), 64'd0);
    check("t3_rst_pc",  m_pc,       64'd0);
    check("t3_rst_ret", 64'(m_ret), 64'd0);
    chkreg("t3_rst_x2", 2, 64'd0);
    @(posedge clk);
    #1;
    rst32 = 1'b0;
    run_ret("t3_again_ret", 1, 10, cyc);
    check("t3_again_cycles", 64'(cyc), 64'd2);
    run_ret("t3_slli_ret", 1, 40, cyc);
    check("t3_slli_cycles", 64'(cyc), 64'd22);
    @(negedge clk);
    chkreg("t3_x1", 1, 64'd3);
    chkreg("t3_x2", 2, 64'h0030_0000);

    // taken branch, jal backwards, jalr with bit 0 cleared
    clear_mem();
    mem[0]    = enc_i(7, 0, 0, 1, OPIMM);
    mem[1]    = enc_i(7, 0, 0, 2, OPIMM);
    mem[2]    = enc_j(32'h0F8, 0);
    mem[8'h40] = enc_b(12, 2, 1, 0);
    mem[8'h41] = enc_i(1, 1, 0, 0, 7'h67);
    mem[8'h42] = enc_i(1, 0, 0, 5, OPIMM);
    mem[8'h43] = enc_j(-8, 1);
    mem[8'h44] = enc_i(1, 0, 0, 3, OPIMM);
    do_reset(1'b0);
    run_ret("t4_pre_ret", 3, 20, cyc);
    run_ret("t4_beq_ret", 1, 10, cyc);
    @(negedge clk);
    check("t4_beq_addr", m_addr, 64'h10C);
    run_ret("t4_jal_ret", 1, 10, cyc);
    @(negedge clk);
    check("t4_jal_addr", m_addr, 64'h104);
    run_ret("t4_jalr_ret", 1, 10, cyc);
    @(negedge clk);
    check("t4_jalr_addr", m_addr, 64'h110);
    chkreg("t4_x1", 1, 64'h110);
    check("t4_trap", 64'(m_trap), 64'd0);

    // load traps: halts with PC frozen
    clear_mem();
    mem[0] = enc_j(32'h20, 0);
    mem[8] = enc_i(0, 0, 2, 1, 7'h03);
    do_reset(1'b0);
    run_ret("t5a_jal_ret", 1, 10, cyc);
    @(negedge clk);
    check("t5a_fetch_addr", m_addr, 64'h20);
    @(negedge clk);
    check("t5a_exec_ret",  64'(m_ret),  64'd0);
    check("t5a_exec_trap", 64'(m_trap), 64'd0);
    @(negedge clk);
    check("t5a_trap", 64'(m_trap), 64'd1);
    check("t5a_pc",   m_pc,        64'h20);
    check("t5a_req",  64'(m_req),  64'd0);
    rcount = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (m_ret || m_req) rcount++;
    end
    check("t5a_quiet", 64'(rcount), 64'd0);
    check("t5a_sticky", 64'(m_trap), 64'd1);
    chkreg("t5a_x1", 1, 64'd0);

    // misaligned branch target
    clear_mem();
    mem[0] = enc_b(2, 0, 0, 0);
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    check("t5b_trap", 64'(m_trap), 64'd1);
    check("t5b_pc",   m_pc,        64'd0);

    // slli with imm[5] set on RV32
    clear_mem();
    mem[0] = enc_i(32, 0, 1, 1, OPIMM);
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    check("t5c_trap", 64'(m_trap), 64'd1);

    // XLEN=64: 63-bit logical shift and x0 write discard
    clear_mem();
    mem[0] = enc_i(-1, 0, 0, 1, OPIMM);
    mem[1] = enc_i(63, 1, 5, 2, OPIMM);
    mem[2] = enc_i(9, 0, 0, 0, OPIMM);
    do_reset(1'b1);
    run_ret("t6_addi_ret", 1, 10, cyc);
    run_ret("t6_srli_ret", 1, 100, cyc);
    check("t6_srli_cycles", 64'(cyc), 64'd65);
    run_ret("t6_x0_ret", 1, 10, cyc);
    @(negedge clk);
    chkreg("t6_x1", 1, 64'hFFFF_FFFF_FFFF_FFFF);
    chkreg("t6_x2", 2, 64'd1);
    chkreg("t6_x0", 0, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
